uart_fifo_core: RTL and testbench

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_fifo_core.sv | 214 +++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART transmitter with TX FIFO and single-buffered receiver
// Frames are 1 start bit, DATA_W data bits LSB first and 1 stop bit, each CLK_DIV cycles long.
module uart_fifo_core #(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_busy,
   output logic              uart_tx,
   input  logic              uart_rx,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [3:0]    BIT_LAST  = 4'(DATA_W - 1);
   localparam logic [3:0]    BIT_ONE   = 4'd1;
   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ---------------- TX FIFO ----------------
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;

   // Extra MSB on the pointers separates full from empty when the index bits match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign tx_ready   = !fifo_full;
   assign push       = tx_valid && !fifo_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= tx_data;
   end

   // ---------------- TX FSM ----------------
   state_t            tx_state;
   state_t            tx_next;
   logic [CW-1:0]     tx_cnt;
   logic [3:0]        tx_bit;
   logic [DATA_W-1:0] tx_shift;
   logic              tx_line;
   logic              tx_cnt_done;

   assign tx_cnt_done = (tx_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) tx_state <= S_IDLE;
      else        tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      pop     = 1'b0;
      case (tx_state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               tx_next = S_START;
            end
         end
         S_START: if (tx_cnt_done) tx_next = S_DATA;
         S_DATA:  if (tx_cnt_done && tx_bit == BIT_LAST) tx_next = S_STOP;
         S_STOP:  if (tx_cnt_done) tx_next = S_IDLE;
         default: tx_next = S_IDLE;
      endcase
   end

   // The line is registered so each bit holds for exactly CLK_DIV cycles from the state change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_line  <= 1'b1;
      end else begin
         if (tx_state == S_IDLE || tx_cnt_done) tx_cnt <= '0;
         else                                   tx_cnt <= tx_cnt + CNT_ONE;
         case (tx_state)
            S_IDLE: begin
               if (pop) begin
                  tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
                  tx_line  <= 1'b0;
                  tx_bit   <= '0;
               end
            end
            S_START: if (tx_cnt_done) tx_line <= tx_shift[0];
            S_DATA: begin
               if (tx_cnt_done) begin
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= tx_bit + BIT_ONE;
                  tx_line  <= (tx_bit == BIT_LAST) ? 1'b1 : tx_shift[1];
               end
            end
            default: tx_line <= 1'b1;
         endcase
      end
   end

   assign uart_tx = tx_line;
   assign tx_busy = !fifo_empty || (tx_state != S_IDLE);

   // ---------------- RX ----------------
   logic              rx_s1;
   logic              rx_s2;
   logic              rx_d;
   state_t            rx_state;
   state_t            rx_next;
   logic [CW-1:0]     rx_cnt;
   logic [3:0]        rx_bit;
   logic [DATA_W-1:0] rx_shift;
   logic              rx_cnt_done;
   logic              rx_deliver;
   logic              rx_bad;

   assign rx_cnt_done = (rx_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) rx_state <= S_IDLE;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next    = rx_state;
      rx_deliver = 1'b0;
      rx_bad     = 1'b0;
      case (rx_state)
         S_IDLE:  if (rx_d && !rx_s2) rx_next = S_START;
         S_START: if (rx_cnt == HALF_LAST) rx_next = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (rx_cnt_done && rx_bit == BIT_LAST) rx_next = S_STOP;
         S_STOP: begin
            if (rx_cnt_done) begin
               rx_next    = S_IDLE;
               rx_deliver = rx_s2;
               rx_bad     = !rx_s2;
            end
         end
         default: rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_d       <= 1'b1;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_s1     <= uart_rx;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         frame_err <= rx_bad;
         if (rx_state == S_IDLE || rx_next != rx_state || rx_cnt_done) rx_cnt <= '0;
         else                                                          rx_cnt <= rx_cnt + CNT_ONE;
         if (rx_state == S_START) begin
            rx_bit <= '0;
         end else if (rx_state == S_DATA && rx_cnt_done) begin
            rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            rx_bit   <= rx_bit + BIT_ONE;
         end
         // Single holding register: an unread byte wins over a newly arrived one.
         if (rx_deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= rx_shift;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - directed self-checking bench for uart_fifo_core
module tb_uart_fifo_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       uart_tx;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_overrun;
   logic       frame_err;

   int total = 0;
   int bad   = 0;

   logic tx_log[$];
   int   fe_cycles = 0;

   always #5 clk = ~clk;

   uart_fifo_core #(
      .DATA_W    (8),
      .CLK_DIV   (16),
      .FIFO_DEPTH(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_busy   (tx_busy),
      .uart_tx   (uart_tx),
      .uart_rx   (uart_rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_overrun(rx_overrun),
      .frame_err (frame_err)
   );

   always @(negedge clk) begin
      tx_log.push_back(uart_tx);
      if (frame_err === 1'b1) fe_cycles++;
   end

   task automatic grab_bit(output logic [15:0] v);
      for (int c = 0; c < 16; c++) begin
         v[c] = uart_tx;
         @(negedge clk);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = fr[i];
         repeat (16) @(negedge clk);
      end
      uart_rx = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; uart_rx = 1'b1; rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
      total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_rx_overrun: got %b expected 0", rx_overrun); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      rst_n = 1'b1;
   endtask

   task automatic test_tx_single;
      logic [9:0]  fr;
      logic [15:0] v;
      fr = {1'b1, 8'hA5, 1'b0};
      @(negedge clk); tx_data = 8'hA5; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL single_pop_cycle_line: got %b expected 1", uart_tx); end
      total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b expected 1", tx_busy); end
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         grab_bit(v);
         total++;
         if (v !== {16{fr[i]}}) begin
            bad++; $display("FAIL single_bit%0d: got %h expected %h", i, v, {16{fr[i]}});
         end
      end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after_stop: got %b expected 0", tx_busy); end
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL single_idle_line: got %b expected 1", uart_tx); end
   endtask

   task automatic test_tx_fifo_full;
      logic [7:0]  bytes [5];
      logic [9:0]  fr;
      logic [15:0] v;
      logic        any_zero;
      int          base;
      int          s0;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
      base = tx_log.size();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL fifo_ready_push%0d: got %b expected 1", k, tx_ready); end
         tx_data = bytes[k]; tx_valid = 1'b1;
      end
      @(negedge clk);
      total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL fifo_full_ready: got %b expected 0", tx_ready); end
      tx_data = 8'h66;
      @(negedge clk); tx_valid = 1'b0;
      total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL fifo_full_after_ignored: got %b expected 0", tx_ready); end
      repeat (900) @(negedge clk);
      s0 = -1;
      for (int i = base; i < tx_log.size(); i++) begin
         if (tx_log[i] === 1'b0) begin s0 = i; break; end
      end
      total++;
      if (s0 < 0 || s0 + 815 > tx_log.size()) begin
         bad++; $display("FAIL fifo_frames_found: start index %0d log size %0d", s0, tx_log.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            fr = {1'b1, bytes[k], 1'b0};
            for (int i = 0; i < 10; i++) begin
               for (int c = 0; c < 16; c++) v[c] = tx_log[s0 + k * 161 + i * 16 + c];
               total++;
               if (v !== {16{fr[i]}}) begin
                  bad++; $display("FAIL fifo_frame%0d_bit%0d: got %h expected %h", k, i, v, {16{fr[i]}});
               end
            end
         end
         any_zero = 1'b0;
         for (int i = s0 + 805; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) any_zero = 1'b1;
         total++; if (any_zero !== 1'b0) begin bad++; $display("FAIL fifo_extra_frame: line left idle got %b expected 0", any_zero); end
      end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL fifo_busy_end: got %b expected 0", tx_busy); end
   endtask

   task automatic test_rx_overrun;
      rx_ready = 1'b0;
      @(negedge clk);
      send_rx(8'h3C, 1'b1);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx1_valid: got %b expected 1", rx_valid); end
      total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL rx1_data: got %h expected 3c", rx_data); end
      total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL rx1_overrun: got %b expected 0", rx_overrun); end
      repeat (4) @(negedge clk);
      send_rx(8'h55, 1'b1);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx2_valid: got %b expected 1", rx_valid); end
      total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL rx2_data_kept: got %h expected 3c", rx_data); end
      total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL rx2_overrun: got %b expected 1", rx_overrun); end
      rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_read_valid: got %b expected 0", rx_valid); end
      total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL rx_read_overrun: got %b expected 0", rx_overrun); end
      repeat (4) @(negedge clk);
      send_rx(8'hC3, 1'b1);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx3_valid: got %b expected 1", rx_valid); end
      total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL rx3_data: got %h expected c3", rx_data); end
      rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame_err;
      int fe0;
      fe0 = fe_cycles;
      send_rx(8'h5A, 1'b0);
      repeat (20) @(negedge clk);
      total++; if (fe_cycles - fe0 !== 1) begin bad++; $display("FAIL ferr_pulse_cycles: got %0d expected 1", fe_cycles - fe0); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ferr_rx_valid: got %b expected 0", rx_valid); end
      total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL ferr_rx_data: got %h expected c3", rx_data); end
   endtask

   task automatic test_glitch;
      int fe0;
      fe0 = fe_cycles;
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cycles - fe0); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_rx_valid: got %b expected 0", rx_valid); end
      send_rx(8'hA7, 1'b1);
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL glitch_next_valid: got %b expected 1", rx_valid); end
      total++; if (rx_data !== 8'hA7) begin bad++; $display("FAIL glitch_next_data: got %h expected a7", rx_data); end
   endtask

   task automatic test_reset_mid_tx;
      logic [7:0] d;
      logic       any_zero;
      int         base;
      int         s0;
      @(negedge clk); tx_data = 8'h96; tx_valid = 1'b1;
      @(negedge clk); tx_data = 8'h3B;
      @(negedge clk); tx_data = 8'h77;
      @(negedge clk); tx_valid = 1'b0;
      repeat (69) @(negedge clk);
      total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL rst_mid_bit3_line: got %b expected 0", uart_tx); end
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_mid_uart_tx: got %b expected 1", uart_tx); end
      total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_tx_ready: got %b expected 1", tx_ready); end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_tx_busy: got %b expected 0", tx_busy); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx_data: got %h expected 00", rx_data); end
      rst_n = 1'b1; tx_data = 8'hE1; tx_valid = 1'b1;
      base = tx_log.size();
      @(negedge clk); tx_valid = 1'b0;
      total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL rst_first_push: busy got %b expected 1", tx_busy); end
      repeat (200) @(negedge clk);
      s0 = -1;
      for (int i = base; i < tx_log.size(); i++) begin
         if (tx_log[i] === 1'b0) begin s0 = i; break; end
      end
      total++;
      if (s0 < 0 || s0 - base > 3 || s0 + 170 > tx_log.size()) begin
         bad++; $display("FAIL rst_after_frame_start: start offset %0d expected 0..3", s0 - base);
      end else begin
         for (int i = 0; i < 8; i++) d[i] = tx_log[s0 + 16 * (i + 1) + 8];
         total++; if (d !== 8'hE1) begin bad++; $display("FAIL rst_after_frame_data: got %h expected e1", d); end
         any_zero = 1'b0;
         for (int i = s0 + 144; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) any_zero = 1'b1;
         total++; if (any_zero !== 1'b0) begin bad++; $display("FAIL rst_lost_frames_sent: line left idle got %b expected 0", any_zero); end
      end
      total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_end_busy: got %b expected 0", tx_busy); end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_tx_fifo_full();
      test_rx_overrun();
      test_frame_err();
      test_glitch();
      test_reset_mid_tx();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
